// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, full/empty, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read data; the default is a registered read port.
module fifo_sync_param #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AFULL_THR  = 14,
    parameter int unsigned AEMPTY_THR = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  WE,
    input  logic                  RE,
    output logic [WIDTH-1:0]      DOUT,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic                  OVF,
    output logic                  UDF
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned AW    = DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          wr_ok;
    logic          rd_ok;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    assign wr_ok = WE & ~full_q;
    assign rd_ok = RE & ~empty_q;
    assign waddr = wptr_q[AW-1:0];
    assign raddr = rptr_q[AW-1:0];

    // Pointer, occupancy and flag next-state; flags decode the next count so they track COUNT exactly
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
        full_d   = (count_d == PW'(DEPTH));
        empty_d  = (count_d == PW'(0));
        afull_d  = (count_d >= PW'(AFULL_THR));
        aempty_d = (count_d <= PW'(AEMPTY_THR));
        ovf_d    = WE & full_q;
        udf_d    = RE & empty_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_q[waddr] <= DIN;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown as soon as it exists; RE only pops it
    assign DOUT = empty_q ? '0 : mem_q[raddr];
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_ok) begin
            dout_d = mem_q[raddr];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign DOUT = dout_q;
`endif

    assign COUNT  = count_q;
    assign FULL   = full_q;
    assign EMPTY  = empty_q;
    assign AFULL  = afull_q;
    assign AEMPTY = aempty_q;
    assign OVF    = ovf_q;
    assign UDF    = udf_q;

endmodule
